// File: rtl/modmul_pkg.sv
// Shared types and constants for the modular-multiply requester and its benches.
package modmul_pkg;

    localparam int W = 64;

    // Modulus used by montgomery_top.
    localparam logic [W-1:0] N = 64'hFFFFFFFFFFFFFFF1;

    typedef logic [W-1:0] operand_t;
    typedef logic [W-1:0] result_t;

    // Plain (a * b) mod N, for reference models outside the datapath.
    function automatic result_t ref_modmul(input operand_t a, input operand_t b);
        logic [2*W-1:0] prod;
        prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        return result_t'(prod % {{W{1'b0}}, N});
    endfunction

endpackage

// File: rtl/modmul_result_fifo.sv
// Result FIFO: synchronous push/pop, asynchronous reset, head word always
// visible on pop_data. Push when full and pop when empty are ignored.
module modmul_result_fifo
    import modmul_pkg::*;
#(
    parameter int W     = 64,
    parameter int DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [W-1:0]                 push_data,
    input  logic                         pop,
    output logic [W-1:0]                 pop_data,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign pop_data = mem[rd_ptr];

    // Storage, pointers and occupancy; memory is cleared so the head reads 0 after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/modmul_requester.sv
// Initiator for montgomery_top: holds one operand pair, issues it under a
// credit check that reserves result FIFO space for everything in flight, and
// streams returned results downstream in issue order.
//
// Handshakes: a transfer happens on a rising clk edge when both sides of a
// pair are high in the cycle before it (s_valid/s_ready, mm_taken/mm_ready_in,
// mm_ready_out/mm_given, m_valid/m_ready). A valid side keeps its data stable
// until the transfer.
module modmul_requester
    import modmul_pkg::*;
#(
    parameter int W         = 64,
    parameter int MAX_OUT   = 8,
    parameter int RES_DEPTH = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           s_valid,
    output logic                           s_ready,
    input  logic [W-1:0]                   s_a,
    input  logic [W-1:0]                   s_b,
    output logic [W-1:0]                   mm_a,
    output logic [W-1:0]                   mm_b,
    output logic                           mm_taken,
    input  logic                           mm_ready_in,
    input  logic [W-1:0]                   mm_result,
    input  logic                           mm_ready_out,
    output logic                           mm_given,
    output logic                           m_valid,
    input  logic                           m_ready,
    output logic [W-1:0]                   m_result,
    output logic [$clog2(MAX_OUT+1)-1:0]   outstanding,
    output logic                           idle,
    output logic                           err_unexpected
);

    localparam int OW = $clog2(MAX_OUT + 1);
    localparam int CW = $clog2(RES_DEPTH + 1);
    localparam int SW = $clog2(MAX_OUT + RES_DEPTH + 1);

    localparam logic [OW-1:0] MAX_OUT_C   = OW'(MAX_OUT);
    localparam logic [SW-1:0] RES_DEPTH_C = SW'(RES_DEPTH);

    logic          hold_valid;
    logic [CW-1:0] fifo_count;
    logic          fifo_full;
    logic          fifo_empty;
    logic [SW-1:0] in_flight;
    logic          credit_ok;
    logic          issue;
    logic          s_fire;
    logic          ret;
    logic          push;
    logic          pop;

    // Results owed plus results queued; wide enough that the sum never wraps.
    assign in_flight = SW'(outstanding) + SW'(fifo_count);
    assign credit_ok = (outstanding < MAX_OUT_C) && (in_flight < RES_DEPTH_C);

    assign mm_taken = hold_valid & credit_ok;
    assign issue    = mm_taken & mm_ready_in;
    // The hold register frees up in the same cycle it issues.
    assign s_ready  = ~hold_valid | issue;
    assign s_fire   = s_valid & s_ready;

    assign mm_given = ~fifo_full;
    assign ret      = mm_ready_out & mm_given;
    // A return with nothing in flight is a protocol error and is dropped.
    assign push     = ret & (outstanding != '0);

    assign m_valid  = ~fifo_empty;
    assign pop      = m_valid & m_ready;

    assign idle     = ~hold_valid & (outstanding == '0) & fifo_empty;

    // Operand hold register; mm_a/mm_b only change when a new pair is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_valid <= 1'b0;
            mm_a       <= '0;
            mm_b       <= '0;
        end else begin
            if (s_fire) begin
                mm_a <= s_a;
                mm_b <= s_b;
            end
            hold_valid <= s_fire | (hold_valid & ~issue);
        end
    end

    // In-flight counter: up on issue, down on a counted return.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outstanding <= '0;
        end else begin
            case ({issue, push})
                2'b10:   outstanding <= outstanding + OW'(1);
                2'b01:   outstanding <= outstanding - OW'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

    // Sticky flag for a result that arrives when nothing was issued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_unexpected <= 1'b0;
        end else if (ret && (outstanding == '0)) begin
            err_unexpected <= 1'b1;
        end
    end

    modmul_result_fifo #(
        .W     (W),
        .DEPTH (RES_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (mm_result),
        .pop       (pop),
        .pop_data  (m_result),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_modmul_requester.sv
// Bench for modmul_requester with an in-order montgomery_top stub.
module tb_modmul_requester;

    localparam int W         = 64;
    localparam int MAX_OUT   = 8;
    localparam int RES_DEPTH = 8;
    localparam int OW        = $clog2(MAX_OUT + 1);
    localparam logic [63:0] TB_N = 64'hFFFFFFFFFFFFFFF1;

    logic          clk;
    logic          rst;
    logic          s_valid;
    logic          s_ready;
    logic [W-1:0]  s_a;
    logic [W-1:0]  s_b;
    logic [W-1:0]  mm_a;
    logic [W-1:0]  mm_b;
    logic          mm_taken;
    logic          mm_ready_in;
    logic [W-1:0]  mm_result;
    logic          mm_ready_out;
    logic          mm_given;
    logic          m_valid;
    logic          m_ready;
    logic [W-1:0]  m_result;
    logic [OW-1:0] outstanding;
    logic          idle;
    logic          err_unexpected;

    modmul_requester #(
        .W         (W),
        .MAX_OUT   (MAX_OUT),
        .RES_DEPTH (RES_DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .s_a            (s_a),
        .s_b            (s_b),
        .mm_a           (mm_a),
        .mm_b           (mm_b),
        .mm_taken       (mm_taken),
        .mm_ready_in    (mm_ready_in),
        .mm_result      (mm_result),
        .mm_ready_out   (mm_ready_out),
        .mm_given       (mm_given),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .m_result       (m_result),
        .outstanding    (outstanding),
        .idle           (idle),
        .err_unexpected (err_unexpected)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1);
    end

    // ---------------- bench state ----------------
    typedef struct packed {
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
    } op_t;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    op_t         up_q[$];     // pairs waiting to be offered upstream
    logic [63:0] exp_q[$];    // expected results, in acceptance order
    logic [63:0] iss_a[$];    // accepted but not yet issued operands
    logic [63:0] iss_b[$];
    logic [63:0] stub_q[$];   // montgomery_top stub pipeline
    int          stub_t[$];
    int          last_ready;

    int   m_out;
    int   m_fifo;
    logic m_err;

    int rdy_in_mode;   // 0: always ready, 1: random, 2: never
    int mr_mode;       // 0: m_ready low, 1: high, 2: random
    int lat_lo, lat_hi;
    bit sv_random;
    bit sv_hold;
    bit rogue;

    int issues, pops, first_issue, last_issue, max_out;
    bit saw_ir4, saw_pp;

    vec_t tbl [6];
    op_t  ops3 [10];

    // ---------------- reference ----------------
    function automatic logic [63:0] model_mul(input logic [63:0] a, input logic [63:0] b);
        logic [127:0] p;
        p = 128'(a) * 128'(b);
        return 64'(p % 128'(TB_N));
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic send(input logic [63:0] a, input logic [63:0] b, input logic [63:0] e);
        op_t o;
        o.a = a;
        o.b = b;
        o.exp = e;
        up_q.push_back(o);
    endtask

    task automatic clear_stats();
        issues = 0; pops = 0; first_issue = -1; last_issue = -1; max_out = 0;
        saw_ir4 = 0; saw_pp = 0;
    endtask

    // ---------------- driver / monitor: one clock cycle ----------------
    task automatic tick();
        logic iss, rt, fire, pp;
        int   t;
        @(negedge clk);
        if (rogue) begin
            mm_ready_out = 1'b1;
            mm_result    = 64'hDEADBEEF0BADF00D;
        end else if (stub_q.size() > 0 && stub_t[0] <= cyc) begin
            mm_ready_out = 1'b1;
            mm_result    = stub_q[0];
        end else begin
            mm_ready_out = 1'b0;
            mm_result    = '0;
        end
        case (rdy_in_mode)
            0:       mm_ready_in = 1'b1;
            1:       mm_ready_in = 1'($urandom_range(0, 1));
            default: mm_ready_in = 1'b0;
        endcase
        case (mr_mode)
            0:       m_ready = 1'b0;
            1:       m_ready = 1'b1;
            default: m_ready = 1'($urandom_range(0, 1));
        endcase
        if (!sv_hold) begin
            if (up_q.size() > 0 && (!sv_random || $urandom_range(0, 3) != 0)) begin
                s_valid = 1'b1;
                s_a     = up_q[0].a;
                s_b     = up_q[0].b;
            end else begin
                s_valid = 1'b0;
            end
        end
        #1;
        iss  = mm_taken & mm_ready_in;
        rt   = mm_ready_out & mm_given;
        fire = s_valid & s_ready;
        pp   = m_valid & m_ready;

        // state observed after the previous edge, against the counting model
        check("outstanding", 64'(outstanding), 64'(m_out));
        check("m_valid", 64'(m_valid), 64'(m_fifo > 0));
        check("idle", 64'(idle), 64'(iss_a.size() == 0 && m_out == 0 && m_fifo == 0));
        check("err_unexpected", 64'(err_unexpected), 64'(m_err));
        check("mm_given", 64'(mm_given), 64'(m_fifo < RES_DEPTH));
        check("mm_taken", 64'(mm_taken),
              64'(iss_a.size() > 0 && m_out < MAX_OUT && (m_out + m_fifo) < RES_DEPTH));
        check("s_ready", 64'(s_ready), 64'(iss_a.size() == 0 || iss));
        if (iss_a.size() > 0) begin
            check("mm_a_held", mm_a, iss_a[0]);
            check("mm_b_held", mm_b, iss_b[0]);
        end

        // bookkeeping for the transfers at the coming edge
        if (rt) begin
            if (m_out == 0) begin
                m_err = 1'b1;
            end else begin
                if (iss && m_out == 4) saw_ir4 = 1;
                if (pp) saw_pp = 1;
                m_out--;
                m_fifo++;
            end
            if (!rogue) begin
                void'(stub_q.pop_front());
                void'(stub_t.pop_front());
            end
        end
        if (pp) begin
            if (exp_q.size() == 0) begin
                check("m_result_unexpected_beat", m_result, 64'hX);
            end else begin
                check("m_result", m_result, exp_q.pop_front());
            end
            m_fifo--;
            pops++;
        end
        if (fire) begin
            exp_q.push_back(up_q[0].exp);
            iss_a.push_back(up_q[0].a);
            iss_b.push_back(up_q[0].b);
            void'(up_q.pop_front());
        end
        sv_hold = s_valid & ~s_ready;
        if (iss) begin
            if (iss_a.size() == 0) begin
                check("issue_without_operand", 64'(iss_a.size()), 64'd1);
            end else begin
                t = cyc + $urandom_range(lat_lo, lat_hi);
                if (t < last_ready) t = last_ready;
                last_ready = t;
                stub_t.push_back(t);
                stub_q.push_back(model_mul(iss_a[0], iss_b[0]));
                void'(iss_a.pop_front());
                void'(iss_b.pop_front());
            end
            m_out++;
            issues++;
            if (first_issue < 0) first_issue = cyc;
            last_issue = cyc;
        end
        if (m_out > max_out) max_out = m_out;
        @(posedge clk);
        cyc++;
    endtask

    task automatic run_until_idle(input int limit, input string name);
        int n;
        n = 0;
        while (!(up_q.size() == 0 && iss_a.size() == 0 && m_out == 0 && m_fifo == 0) && n < limit) begin
            tick();
            n++;
        end
        check({name, "_drain_in_budget"}, 64'(n < limit), 64'd1);
        #2;
        check({name, "_idle_end"}, 64'(idle), 64'd1);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_mm_taken"}, 64'(mm_taken), 64'd0);
        check({name, "_m_valid"}, 64'(m_valid), 64'd0);
        check({name, "_mm_a"}, mm_a, 64'd0);
        check({name, "_mm_b"}, mm_b, 64'd0);
        check({name, "_m_result"}, m_result, 64'd0);
        check({name, "_s_ready"}, 64'(s_ready), 64'd1);
        check({name, "_mm_given"}, 64'(mm_given), 64'd1);
        check({name, "_idle"}, 64'(idle), 64'd1);
        check({name, "_outstanding"}, 64'(outstanding), 64'd0);
        check({name, "_err"}, 64'(err_unexpected), 64'd0);
    endtask

    // Reset asserted mid-cycle; the stub is reset along with the block.
    task automatic do_reset(input string name);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs(name);
        up_q.delete(); exp_q.delete(); iss_a.delete(); iss_b.delete();
        stub_q.delete(); stub_t.delete();
        last_ready = 0; m_out = 0; m_fifo = 0; m_err = 1'b0;
        s_valid = 1'b0; sv_hold = 0; mm_ready_out = 1'b0; rogue = 0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        tbl[0] = '{64'd5,  64'd7,  64'h23};
        tbl[1] = '{64'd3,  64'd4,  64'hC};
        tbl[2] = '{64'd6,  64'd8,  64'h30};
        tbl[3] = '{64'hA,  64'hF,  64'h96};
        tbl[4] = '{64'd1,  64'd1,  64'h1};
        tbl[5] = '{64'hFFFFFFFFFFFFFFFE, 64'd2, 64'h1A};

        rst = 1'b1; s_valid = 1'b0; s_a = '0; s_b = '0;
        mm_ready_in = 1'b0; mm_result = '0; mm_ready_out = 1'b0; m_ready = 1'b0;
        m_out = 0; m_fifo = 0; m_err = 1'b0; last_ready = 0;
        rdy_in_mode = 0; mr_mode = 1; lat_lo = 3; lat_hi = 3;
        sv_random = 0; sv_hold = 0; rogue = 0;
        clear_stats();
        #2;
        check_reset_outputs("power_on");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // 1: single operation
        clear_stats();
        for (int i = 0; i < 1; i++) send(tbl[i].a, tbl[i].b, tbl[i].exp);
        run_until_idle(100, "single");
        check("single_beats", 64'(pops), 64'd1);
        check("single_max_outstanding", 64'(max_out), 64'd1);

        // 2: back-to-back stream, one issue per cycle
        clear_stats();
        for (int i = 1; i <= 4; i++) send(tbl[i].a, tbl[i].b, tbl[i].exp);
        run_until_idle(100, "stream");
        check("stream_beats", 64'(pops), 64'd4);
        check("stream_issues", 64'(issues), 64'd4);
        check("stream_issue_span", 64'(last_issue - first_issue), 64'd3);

        // 3: downstream stalled, credit limits issue to the FIFO depth
        clear_stats();
        mr_mode = 0; lat_lo = 2; lat_hi = 2;
        for (int i = 0; i < 10; i++) begin
            ops3[i].a   = {$urandom, $urandom};
            ops3[i].b   = {$urandom, $urandom};
            ops3[i].exp = model_mul(ops3[i].a, ops3[i].b);
            send(ops3[i].a, ops3[i].b, ops3[i].exp);
        end
        repeat (40) tick();
        #2;
        check("stall_issues", 64'(issues), 64'(RES_DEPTH));
        check("stall_mm_taken", 64'(mm_taken), 64'd0);
        check("stall_s_ready", 64'(s_ready), 64'd0);
        check("stall_mm_a", mm_a, ops3[8].a);
        check("stall_mm_b", mm_b, ops3[8].b);
        check("stall_m_valid", 64'(m_valid), 64'd1);
        mr_mode = 1;
        run_until_idle(200, "stall");
        check("stall_beats", 64'(pops), 64'd10);

        // 4: result with nothing in flight
        rogue = 1;
        tick();
        rogue = 0;
        repeat (5) tick();
        #2;
        check("rogue_err", 64'(err_unexpected), 64'd1);
        check("rogue_m_valid", 64'(m_valid), 64'd0);
        check("rogue_outstanding", 64'(outstanding), 64'd0);

        // 5: reset with 2 results queued and 3 in flight
        clear_stats();
        mr_mode = 0; lat_lo = 2; lat_hi = 2;
        for (int i = 0; i < 2; i++) send({$urandom, $urandom}, 64'd3, 64'd0);
        for (int i = 0; i < 2; i++) exp_q.push_back(64'd0);
        begin
            int n = 0;
            while (m_fifo < 2 && n < 50) begin tick(); n++; end
            lat_lo = 60; lat_hi = 60;
            for (int i = 0; i < 3; i++) send(64'd9, 64'd9, 64'd81);
            while (m_out < 3 && n < 100) begin tick(); n++; end
            check("pre_reset_setup_in_budget", 64'(n < 100), 64'd1);
        end
        do_reset("mid_reset");
        clear_stats();
        mr_mode = 1; lat_lo = 3; lat_hi = 3;
        send(tbl[5].a, tbl[5].b, tbl[5].exp);
        run_until_idle(100, "after_reset");
        check("after_reset_beats", 64'(pops), 64'd1);

        // 6: issue and return in the same cycle at steady occupancy
        clear_stats();
        lat_lo = 4; lat_hi = 4;
        for (int i = 0; i < 12; i++) begin
            logic [63:0] a, b;
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            send(a, b, model_mul(a, b));
        end
        run_until_idle(200, "overlap");
        check("overlap_issue_ret_at_4", 64'(saw_ir4), 64'd1);
        check("overlap_push_pop", 64'(saw_pp), 64'd1);
        check("overlap_beats", 64'(pops), 64'd12);

        // randomized traffic on every interface
        clear_stats();
        sv_random = 1; rdy_in_mode = 1; mr_mode = 2; lat_lo = 1; lat_hi = 6;
        for (int i = 0; i < 300; i++) begin
            logic [63:0] a, b;
            a = {$urandom, $urandom};
            b = ($urandom_range(0, 7) == 0) ? TB_N - 64'(1) : {$urandom, $urandom};
            send(a, b, model_mul(a, b));
        end
        run_until_idle(20000, "random");
        check("random_beats", 64'(pops), 64'd300);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
